ysyx_24110015_mem_arbiter: RTL and testbench
============================================

Name: ysyx_24110015_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the multi-cycle core.
- Sequences exactly one outstanding transaction at a time: grant, issue, wait for response, then return the response to the owner.
- Includes a response timeout watchdog, so a stalled memory cannot hang the core.
- Sits between the core's IFU/LSU and the single memory interface, replacing the direct inst input of the single-cycle top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. wmask width is DATA_W/8.
- TIMEOUT, 1024, number of WAIT cycles before the watchdog fires. Counter width is clog2(TIMEOUT)+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_req_valid  in  1  IFU request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  fetch response valid (one-cycle pulse).
- ifu_rsp_data  out  DATA_W  fetched instruction.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  byte enables.
- lsu_rsp_valid  out  1  LSU response valid (one-cycle pulse).
- lsu_rsp_data  out  DATA_W  load data; undefined for stores.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields.
- mem_rsp_valid  in  1  memory response.
- mem_rsp_data  in  DATA_W  memory read data.
- rsp_err  out  1  qualifies the current x_rsp_valid as a timeout response.

Behaviour:
- States: IDLE, REQ, WAIT. An owner register (IFU/LSU) is valid in REQ and WAIT.
- IDLE:
  - If any x_req_valid is high, select a winner and assert x_req_ready for that winner only, combinationally in the same cycle.
  - On that edge, latch addr/wen/wdata/wmask and owner, then go to REQ.
  - IFU grants latch wen=0 and wmask=0.
- REQ:
  - mem_req_valid=1 with the latched fields held stable.
  - When mem_req_ready=1, go to WAIT and clear the timeout counter.
  - mem_req_valid must never drop before ready.
- WAIT:
  - mem_req_valid=0.
  - When mem_rsp_valid=1: owner_rsp_valid=1 and owner_rsp_data=mem_rsp_data in the same cycle (combinational pass-through), rsp_err=0; next state IDLE.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 with no response: owner_rsp_valid=1, data=0, rsp_err=1; next state IDLE.
- Minimum latency: accept at cycle 0, mem_req_valid at cycle 1, response pulse at cycle 2 with zero-wait memory. A new grant is possible in the cycle after the response.
- Default fixed priority: LSU wins over IFU when both are valid in IDLE.
- x_req_ready is 0 outside IDLE. Requesters hold valid until ready.
- mem_rsp_valid is ignored in IDLE and REQ. A stray or late response produces no x_rsp_valid.
- The non-owner's rsp_valid is always 0.
- Reset (any state, including mid-transaction):
  - state=IDLE, counter=0, owner=IFU, latched fields=0.
  - All outputs: valid/ready=0, data=0, rsp_err=0.
  - In-flight transactions are dropped with no response.

Optional Feature:
- Macro: YSYX_24110015_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant register (reset value IFU) is updated at each grant. When both requesters are valid, the one not granted last wins. A single requester always wins.
- Undefined: fixed LSU priority; no last_grant register exists.

Test Plan:
- Single IFU fetch: ifu_addr=0x80000000, memory ready immediately and rsp next cycle with 0x00100073 -> mem_req_valid at cycle 1 with mem_addr=0x80000000, mem_wen=0; ifu_rsp_valid=1 with data 0x00100073 at cycle 2; lsu_rsp_valid stays 0.
- Store with backpressure: lsu addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready low for 3 cycles -> fields stable for all 4 REQ cycles; lsu_rsp_valid one pulse after mem_rsp_valid.
- Simultaneous requests, IFU addr 0x80000004 and LSU addr 0x80002000:
  - Without macro: LSU is served first; IFU is served next; ifu_req_ready never high while busy.
  - With macro: repeated contention alternates IFU, LSU, IFU.
- Timeout with TIMEOUT=8: no mem_rsp_valid after the request is accepted -> after 8 WAIT cycles, owner_rsp_valid=1, rsp_err=1, data=0; returns to IDLE and accepts the next request.
- Reset mid-WAIT, then mem_rsp_valid arrives one cycle after reset deasserts -> no x_rsp_valid; all outputs 0; the next request proceeds normally.
- Stray mem_rsp_valid=1 pulsed in IDLE -> no response output and no state change.

Source files
------------

// File: rtl/ysyx_24110015_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the memory arbiter and the single memory port.
// The master view belongs to the arbiter; the slave view belongs to the core and memory side.
interface ysyx_24110015_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid;
  logic [DATA_W-1:0] ifu_rsp_data;

  logic                ifu_unused_pad;
  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_rsp_valid;
  logic [DATA_W-1:0]   lsu_rsp_data;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_data;

  logic                rsp_err;

  modport master (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output rsp_err
  );

  modport slave (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  rsp_err
  );
endinterface

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Single-outstanding IFU/LSU memory arbiter with response watchdog.
// Define YSYX_24110015_ARB_RR_EN for round-robin arbitration; fixed LSU priority otherwise.
module ysyx_24110015_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_24110015_mem_arbiter_if.master  bus
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]          state;
  logic                owner;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;

  logic                grant_any;
  logic                grant_lsu;
  logic                timeout_hit;
  logic                rsp_fire;
  logic [DATA_W-1:0]   rsp_data;

`ifdef YSYX_24110015_ARB_RR_EN
  logic last_grant;

  // Under contention the requester that did not win last time takes the port.
  always_comb begin
    grant_lsu = bus.lsu_req_valid;
    if (bus.lsu_req_valid && bus.ifu_req_valid)
      grant_lsu = (last_grant == OWN_IFU);
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= OWN_IFU;
    else if (grant_any)
      last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
  end
`else
  always_comb grant_lsu = bus.lsu_req_valid;
`endif

  assign grant_any   = !rst && (state == S_IDLE) && (bus.ifu_req_valid || bus.lsu_req_valid);
  assign timeout_hit = (cnt == CNT_LAST);
  assign rsp_fire    = !rst && (state == S_WAIT) && (bus.mem_rsp_valid || timeout_hit);
  assign rsp_data    = bus.mem_rsp_valid ? bus.mem_rsp_data : '0;

  assign bus.ifu_req_ready = grant_any && !grant_lsu;
  assign bus.lsu_req_ready = grant_any && grant_lsu;

  assign bus.ifu_rsp_valid = rsp_fire && (owner == OWN_IFU);
  assign bus.lsu_rsp_valid = rsp_fire && (owner == OWN_LSU);
  assign bus.ifu_rsp_data  = bus.ifu_rsp_valid ? rsp_data : '0;
  assign bus.lsu_rsp_data  = bus.lsu_rsp_valid ? rsp_data : '0;
  assign bus.rsp_err       = rsp_fire && !bus.mem_rsp_valid;

  assign bus.mem_req_valid = !rst && (state == S_REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      owner   <= OWN_IFU;
      cnt     <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            state <= S_REQ;
            if (grant_lsu) begin
              owner   <= OWN_LSU;
              addr_q  <= bus.lsu_addr;
              wen_q   <= bus.lsu_wen;
              wdata_q <= bus.lsu_wdata;
              wmask_q <= bus.lsu_wmask;
            end else begin
              owner   <= OWN_IFU;
              addr_q  <= bus.ifu_addr;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              wmask_q <= '0;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            state <= S_WAIT;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          // A real response wins over a watchdog expiry in the same cycle.
          if (bus.mem_rsp_valid || timeout_hit)
            state <= S_IDLE;
          else
            cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter (default fixed-priority build, TIMEOUT=8).
module tb_ysyx_24110015_mem_arbiter;
  typedef struct {
    bit          lsu;
    logic [31:0] data;
    bit          err;
    bit          chk_data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  exp_t mon_e;

  ysyx_24110015_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  function automatic logic own_vld(input bit lsu);
    return lsu ? bus.lsu_rsp_valid : bus.ifu_rsp_valid;
  endfunction

  // Response monitor: every response pulse must match the oldest accepted request.
  always @(negedge clk) begin
    #3;
    if (!rst && (bus.ifu_rsp_valid || bus.lsu_rsp_valid)) begin
      chk("rsp_both", {63'd0, bus.ifu_rsp_valid & bus.lsu_rsp_valid}, 64'd0);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_owner", {63'd0, bus.lsu_rsp_valid}, {63'd0, mon_e.lsu});
        chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, mon_e.err});
        if (mon_e.chk_data)
          chk("rsp_data", {32'd0, mon_e.lsu ? bus.lsu_rsp_data : bus.ifu_rsp_data},
              {32'd0, mon_e.data});
      end
    end
  end

  // lat < 0 means memory never answers and the watchdog must fire.
  task automatic run_txn(input bit lsu, input logic [31:0] addr, input bit wen,
                         input logic [31:0] wd, input logic [3:0] wm,
                         input int stall, input int lat, input logic [31:0] rd);
    logic [31:0] ewd;
    logic [3:0]  ewm;
    ewd = lsu ? wd : 32'd0;
    ewm = lsu ? wm : 4'd0;
    tick();
    if (lsu) begin
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = addr;
      bus.lsu_wen       = wen;
      bus.lsu_wdata     = wd;
      bus.lsu_wmask     = wm;
    end else begin
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = addr;
    end
    #1;
    chk("grant_ready", {63'd0, lsu ? bus.lsu_req_ready : bus.ifu_req_ready}, 64'd1);
    chk("grant_other", {63'd0, lsu ? bus.ifu_req_ready : bus.lsu_req_ready}, 64'd0);
    sb.push_back('{lsu: lsu, data: (lat < 0) ? 32'd0 : rd, err: (lat < 0),
                   chk_data: (lat < 0) || !wen});
    for (int i = 0; i <= stall; i++) begin
      tick();
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      bus.mem_req_ready = (i == stall);
      #1;
      chk("req_valid", {63'd0, bus.mem_req_valid}, 64'd1);
      chk("req_addr", {32'd0, bus.mem_addr}, {32'd0, addr});
      chk("req_wen", {63'd0, bus.mem_wen}, {63'd0, lsu & wen});
      chk("req_wdata", {32'd0, bus.mem_wdata}, {32'd0, ewd});
      chk("req_wmask", {60'd0, bus.mem_wmask}, {60'd0, ewm});
    end
    if (lat < 0) begin
      for (int i = 0; i < 7; i++) begin
        tick();
        bus.mem_req_ready = 1'b0;
        #1;
        chk("to_early", {63'd0, own_vld(lsu)}, 64'd0);
      end
      tick();
      #1;
      chk("to_vld", {63'd0, own_vld(lsu)}, 64'd1);
      chk("to_err", {63'd0, bus.rsp_err}, 64'd1);
    end else begin
      for (int i = 0; i < lat; i++) begin
        tick();
        bus.mem_req_ready = 1'b0;
        #1;
        chk("wait_reqv", {63'd0, bus.mem_req_valid}, 64'd0);
        chk("wait_rsp", {63'd0, own_vld(lsu)}, 64'd0);
      end
      tick();
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = rd;
      #1;
      chk("rsp_vld", {63'd0, own_vld(lsu)}, 64'd1);
      chk("rsp_reqv", {63'd0, bus.mem_req_valid}, 64'd0);
    end
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1;
    repeat (2) tick();
    #1;
    chk("rst_ifu_ready", {63'd0, bus.ifu_req_ready}, 64'd0);
    chk("rst_mem_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    chk("rst_mem_addr", {32'd0, bus.mem_addr}, 64'd0);
    chk("rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
    tick();
    rst = 1'b0;
    bus.ifu_req_valid = 1'b0;

    // IFU fetch with zero-wait memory
    run_txn(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'd0, 0, 0, 32'h0010_0073);
    // Store with three cycles of backpressure
    run_txn(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'h1234_5678);
    // Load with response latency
    run_txn(1'b1, 32'h8000_0100, 1'b0, 32'd0, 4'hF, 1, 2, 32'hCAFE_F00D);

    // Contention: LSU first, IFU held off until idle
    tick();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0004;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_2000;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wmask     = 4'hF;
    #1;
    chk("cont_lsu_ready", {63'd0, bus.lsu_req_ready}, 64'd1);
    chk("cont_ifu_ready", {63'd0, bus.ifu_req_ready}, 64'd0);
    sb.push_back('{lsu: 1'b1, data: 32'hAAAA_5555, err: 1'b0, chk_data: 1'b1});
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    chk("cont_busy_ifu_ready", {63'd0, bus.ifu_req_ready}, 64'd0);
    chk("cont_addr_lsu", {32'd0, bus.mem_addr}, 64'h8000_2000);
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hAAAA_5555;
    #1;
    chk("cont_wait_ifu_ready", {63'd0, bus.ifu_req_ready}, 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("cont_ifu_grant", {63'd0, bus.ifu_req_ready}, 64'd1);
    sb.push_back('{lsu: 1'b0, data: 32'h5555_AAAA, err: 1'b0, chk_data: 1'b1});
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    chk("cont_addr_ifu", {32'd0, bus.mem_addr}, 64'h8000_0004);
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h5555_AAAA;
    tick();
    bus.mem_rsp_valid = 1'b0;

    // Watchdog on an LSU load, then normal traffic again
    run_txn(1'b1, 32'h8000_3000, 1'b0, 32'd0, 4'hF, 0, -1, 32'd0);
    run_txn(1'b0, 32'h8000_0008, 1'b0, 32'd0, 4'd0, 0, 0, 32'h0000_0013);

    // Reset in WAIT, late response afterwards must be ignored
    tick();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_000C;
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    void'(sb.pop_back());
    tick();
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0BAD_0BAD;
    #1;
    chk("rstw_ifu_vld", {63'd0, bus.ifu_rsp_valid}, 64'd0);
    chk("rstw_lsu_vld", {63'd0, bus.lsu_rsp_valid}, 64'd0);
    chk("rstw_mem_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    chk("rstw_mem_addr", {32'd0, bus.mem_addr}, 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    run_txn(1'b0, 32'h8000_0010, 1'b0, 32'd0, 4'd0, 0, 0, 32'h0020_0093);

    // Stray response in IDLE
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h7777_7777;
    #1;
    chk("stray_ifu_vld", {63'd0, bus.ifu_rsp_valid}, 64'd0);
    chk("stray_lsu_vld", {63'd0, bus.lsu_rsp_valid}, 64'd0);
    chk("stray_mem_valid", {63'd0, bus.mem_req_valid}, 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    run_txn(1'b1, 32'h8000_4000, 1'b0, 32'd0, 4'h3, 0, 0, 32'h0102_0304);

    tick();
    #4;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
